// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor1bit.sv
// rtl/subtractor1bit.sv - combinational one-bit full subtractor cell
module subtractor1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B-Bi subtractor with start/busy/done handshake (optional SERIAL_SUB_OVF_EN adds V)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bi,
    output logic [N-1:0] S,
    output logic         Bo,
    output logic         busy,
    output logic         done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_t state;
    state_t next_state;

    // a_sr doubles as the result register: as minuend bits leave the LSB end,
    // difference bits enter at the MSB end, so after N shifts it is LSB-aligned.
    logic [N-1:0]     a_sr;
    logic [N-1:0]     b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;

    assign last_bit = (cnt == LAST_BIT);

    subtractor1bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, one bit per cycle through the cell, and result commit on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Bo   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            V    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bi;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= {d_bit, a_sr[N-1:1]};
                    b_sr <= b_sr >> 1;
                    br   <= bout_bit;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        S  <= {d_bit, a_sr[N-1:1]};
                        Bo <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into the MSB differs from borrow out of it.
                        V  <= br ^ bout_bit;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int N = 4;
    localparam int MAXV = (1 << N);
    localparam int HALF = (1 << (N - 1));

    typedef struct {
        logic [N-1:0] s;
        logic         bo;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         bi_in = 1'b0;
    logic [N-1:0] s;
    logic         bo;
    logic         busy;
    logic         done;
    logic         v;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int dones = 0;
    int busy_run = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Bi    (bi_in),
        .S     (s),
        .Bo    (bo),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (v)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign v = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and two's-complement views.
    function automatic exp_t model(input int a, input int b, input int bi);
        exp_t e;
        int   diff;
        int   sa;
        int   sbv;
        int   r;
        diff = a - b - bi;
        e.s  = N'((diff + 2 * MAXV) % MAXV);
        e.bo = (a < b + bi);
        sa   = (a >= HALF) ? a - MAXV : a;
        sbv  = (b >= HALF) ? b - MAXV : b;
        r    = sa - sbv - bi;
        e.v  = (r < -HALF) || (r > HALF - 1);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                dones++;
                check("busy_cycles", busy_run, N);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("diff_S", int'(s), int'(e.s));
                    check("borrow_Bo", int'(bo), int'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                    check("overflow_V", int'(v), int'(e.v));
`endif
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    task automatic run_op(input int a, input int b, input int bi, input bit inject);
        exp_t e;
        int   cnt;
        e = model(a, b, bi);
        @(negedge clk);
        a_in  = N'(a);
        b_in  = N'(b);
        bi_in = bi[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(e);
        pushes++;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
        bi_in = 1'($urandom);
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk);
            cnt++;
            #1;
            if (done) break;
            if (inject && cnt == 2) begin
                a_in  = N'(1);
                b_in  = N'(1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_latency", cnt, N);
        @(posedge clk);
        #1;
        check("hold_busy", int'(busy), 0);
        check("hold_done", int'(done), 0);
        check("hold_S", int'(s), int'(e.s));
        check("hold_Bo", int'(bo), int'(e.bo));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_S", int'(s), 0);
        check("rst_Bo", int'(bo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_V", int'(v), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(9, 3, 0, 1'b0);
        run_op(3, 9, 0, 1'b0);
        run_op(0, 0, 1, 1'b0);
        run_op(15, 15, 0, 1'b0);
        run_op(9, 3, 0, 1'b1);
        run_op(8, 1, 0, 1'b0);
        run_op(7, 15, 0, 1'b0);
        run_op(5, 2, 0, 1'b0);

        // Abort mid-operation: state clears and the aborted result never appears.
        @(negedge clk);
        a_in  = N'(9);
        b_in  = N'(3);
        bi_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_S", int'(s), 0);
        check("abort_Bo", int'(bo), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        check("abort_idle_busy", int'(busy), 0);

        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(MAXV - 1, 0)), int'($urandom_range(MAXV - 1, 0)),
                   int'($urandom_range(1, 0)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", sb_q.size(), 0);
        check("done_count", dones, pushes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
